// File: rtl/vx_wctl_issue_pkg.sv
// Shared types for the warp-control issue block.
// Holds the core dimensions, the op and FSM enums, the warp-control
// payload struct and the count clamp used by WSPAWN and BAR.
package vx_wctl_issue_pkg;

    localparam int unsigned NUM_WARPS    = 4;
    localparam int unsigned NUM_THREADS  = 4;
    localparam int unsigned NUM_BARRIERS = 4;
    localparam int unsigned PC_BITS      = 30;
    localparam int unsigned NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
    // Wide enough to hold the value NUM_WARPS itself.
    localparam int unsigned CNT_WIDTH    = $clog2(NUM_WARPS + 1);

    typedef enum logic [1:0] {
        OP_TMC    = 2'd0,
        OP_WSPAWN = 2'd1,
        OP_BAR    = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SINGLE = 2'd1,
        SPAWN_PEND  = 2'd2,
        RSP_HOLD    = 2'd3
    } state_e;

    typedef struct packed {
        logic                   valid;
        logic [NUM_THREADS-1:0] mask;
    } tmc_t;

    typedef struct packed {
        logic                 valid;
        logic [NUM_WARPS-1:0] wmask;
        logic [PC_BITS-1:0]   pc;
    } wspawn_t;

    typedef struct packed {
        logic                valid;
        logic [NB_WIDTH-1:0] id;
        logic                is_global;
        logic [NW_WIDTH-1:0] size_m1;
    } bar_t;

    typedef struct packed {
        tmc_t    tmc;
        wspawn_t wspawn;
        bar_t    bar;
    } wctl_t;

    // Zero or out-of-range counts mean "all warps".
    function automatic logic [CNT_WIDTH-1:0] clamp_count(input logic [31:0] cnt);
        return ((cnt == 32'd0) || (cnt > 32'(NUM_WARPS))) ? CNT_WIDTH'(NUM_WARPS)
                                                          : CNT_WIDTH'(cnt);
    endfunction

endpackage

// File: rtl/vx_wctl_issue_if.sv
// Warp-control issue bus: dispatch request, scheduler status,
// warp-control pulse and commit response.
// master: the issue block (drives req_ready, wctl_*, rsp_*, stall_err)
// slave : the dispatch/scheduler/commit side
interface vx_wctl_issue_if;
    import vx_wctl_issue_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [NW_WIDTH-1:0]    req_wid;
    logic [1:0]             req_op;
    logic [31:0]            req_rs1;
    logic [31:0]            req_rs2;
    logic [NUM_WARPS-1:0]   active_warps;
    logic                   is_single_warp;
    logic                   wctl_valid;
    logic [NW_WIDTH-1:0]    wctl_wid;
    logic                   wctl_tmc_valid;
    logic [NUM_THREADS-1:0] wctl_tmc_mask;
    logic                   wctl_wspawn_valid;
    logic [NUM_WARPS-1:0]   wctl_wspawn_wmask;
    logic [PC_BITS-1:0]     wctl_wspawn_pc;
    logic                   wctl_bar_valid;
    logic [NB_WIDTH-1:0]    wctl_bar_id;
    logic                   wctl_bar_global;
    logic [NW_WIDTH-1:0]    wctl_bar_size_m1;
    logic                   rsp_valid;
    logic [NW_WIDTH-1:0]    rsp_wid;
    logic                   rsp_ready;
    logic                   stall_err;

    modport master (
        input  req_valid, req_wid, req_op, req_rs1, req_rs2,
        input  active_warps, is_single_warp, rsp_ready,
        output req_ready,
        output wctl_valid, wctl_wid, wctl_tmc_valid, wctl_tmc_mask,
        output wctl_wspawn_valid, wctl_wspawn_wmask, wctl_wspawn_pc,
        output wctl_bar_valid, wctl_bar_id, wctl_bar_global, wctl_bar_size_m1,
        output rsp_valid, rsp_wid, stall_err
    );

    modport slave (
        output req_valid, req_wid, req_op, req_rs1, req_rs2,
        output active_warps, is_single_warp, rsp_ready,
        input  req_ready,
        input  wctl_valid, wctl_wid, wctl_tmc_valid, wctl_tmc_mask,
        input  wctl_wspawn_valid, wctl_wspawn_wmask, wctl_wspawn_pc,
        input  wctl_bar_valid, wctl_bar_id, wctl_bar_global, wctl_bar_size_m1,
        input  rsp_valid, rsp_wid, stall_err
    );

endinterface

// File: rtl/vx_wctl_issue_encode.sv
// Combinational formatter: op + operands -> warp-control payload.
// Ports: op, rs1, rs2 in; payload_c out (all-zero for the reserved op).
module vx_wctl_encode
    import vx_wctl_issue_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output wctl_t       payload_c
);

    logic [CNT_WIDTH-1:0] spawn_cnt;
    logic [CNT_WIDTH-1:0] bar_cnt;

    assign spawn_cnt = clamp_count(rs1);
    assign bar_cnt   = clamp_count(rs2);

    always_comb begin
        payload_c = '0;
        case (op)
            OP_TMC: begin
                payload_c.tmc.valid = 1'b1;
                payload_c.tmc.mask  = rs1[NUM_THREADS-1:0];
            end
            OP_WSPAWN: begin
                payload_c.wspawn.valid = 1'b1;
                // Warp 0 is the spawner and is never restarted.
                for (int unsigned i = 1; i < NUM_WARPS; i++) begin
                    payload_c.wspawn.wmask[i] = (CNT_WIDTH'(i) < spawn_cnt);
                end
                payload_c.wspawn.pc = rs2[PC_BITS+1:2];
            end
            OP_BAR: begin
                payload_c.bar.valid     = 1'b1;
                payload_c.bar.id        = rs1[NB_WIDTH-1:0];
                payload_c.bar.is_global = rs1[31];
                payload_c.bar.size_m1   = NW_WIDTH'(bar_cnt - CNT_WIDTH'(1));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vx_wctl_issue.sv
// Warp-control issue master: accepts TMC/WSPAWN/BAR from dispatch,
// emits a one-cycle warp-control pulse plus a commit response, and
// holds off a wspawn until a single warp is active and the spawn shows
// up in active_warps.
// Ports: clk, reset (async, active-high), bus (master modport).
module vx_wctl_issue
    import vx_wctl_issue_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 1024
) (
    input logic             clk,
    input logic             reset,
    vx_wctl_issue_if.master bus
);

    localparam int unsigned WC_WIDTH = $clog2(WAIT_LIMIT + 1);

    state_e               state_q, state_n;
    wctl_t                wctl_q, wctl_n;
    logic                 wctl_valid_q, wctl_valid_n;
    logic [NW_WIDTH-1:0]  wctl_wid_q, wctl_wid_n;
    logic                 rsp_valid_q, rsp_valid_n;
    logic [NW_WIDTH-1:0]  rsp_wid_q, rsp_wid_n;
    wctl_t                pend_q, pend_n;
    logic [NW_WIDTH-1:0]  pend_wid_q, pend_wid_n;
    logic [NUM_WARPS-1:0] snap_q, snap_n;
    logic                 spawn_pend_q, spawn_pend_n;
    logic [WC_WIDTH-1:0]  wait_cnt_q, wait_cnt_n, wait_inc;
    logic                 stall_q, stall_n;
    logic                 req_ready_c, accept, in_wait;
    op_e                  op_c;
    wctl_t                enc_c;

    assign op_c = op_e'(bus.req_op);

    vx_wctl_encode u_encode (
        .op        (op_c),
        .rs1       (bus.req_rs1),
        .rs2       (bus.req_rs2),
        .payload_c (enc_c)
    );

    // Next-state and output formatting.
    always_comb begin
        state_n      = state_q;
        wctl_n       = '0;
        wctl_valid_n = 1'b0;
        wctl_wid_n   = '0;
        rsp_valid_n  = rsp_valid_q && !bus.rsp_ready;
        rsp_wid_n    = rsp_wid_q;
        pend_n       = pend_q;
        pend_wid_n   = pend_wid_q;
        snap_n       = snap_q;
        spawn_pend_n = spawn_pend_q && (bus.active_warps == snap_q);
        wait_cnt_n   = '0;
        wait_inc     = (wait_cnt_q == WC_WIDTH'(WAIT_LIMIT)) ? wait_cnt_q
                                                             : wait_cnt_q + WC_WIDTH'(1);
        in_wait      = (state_q == WAIT_SINGLE) || (state_q == SPAWN_PEND);
        stall_n      = stall_q || (in_wait && (wait_inc == WC_WIDTH'(WAIT_LIMIT)));

        case (state_q)
            IDLE:     req_ready_c = !rsp_valid_q || bus.rsp_ready;
            RSP_HOLD: req_ready_c = bus.rsp_ready && !spawn_pend_n;
            default:  req_ready_c = 1'b0;
        endcase
        accept = bus.req_valid && req_ready_c;

        case (state_q)
            IDLE, RSP_HOLD: begin
                if (accept) begin
                    if ((op_c == OP_WSPAWN) && !bus.is_single_warp) begin
                        // Park the formatted spawn until one warp remains.
                        pend_n     = enc_c;
                        pend_wid_n = bus.req_wid;
                        state_n    = WAIT_SINGLE;
                    end else begin
                        wctl_valid_n = (op_c != OP_RSVD);
                        wctl_n       = enc_c;
                        wctl_wid_n   = (op_c != OP_RSVD) ? bus.req_wid : '0;
                        rsp_valid_n  = 1'b1;
                        rsp_wid_n    = bus.req_wid;
                        if (op_c == OP_WSPAWN) begin
                            snap_n       = bus.active_warps;
                            spawn_pend_n = 1'b1;
                            state_n      = SPAWN_PEND;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end else if (rsp_valid_n) begin
                    state_n = RSP_HOLD;
                end else if (spawn_pend_n) begin
                    state_n = SPAWN_PEND;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT_SINGLE: begin
                wait_cnt_n = wait_inc;
                if (bus.is_single_warp) begin
                    wctl_valid_n = 1'b1;
                    wctl_n       = pend_q;
                    wctl_wid_n   = pend_wid_q;
                    rsp_valid_n  = 1'b1;
                    rsp_wid_n    = pend_wid_q;
                    snap_n       = bus.active_warps;
                    spawn_pend_n = 1'b1;
                    wait_cnt_n   = '0;
                    state_n      = SPAWN_PEND;
                end
            end
            SPAWN_PEND: begin
                wait_cnt_n = wait_inc;
                if (rsp_valid_n) begin
                    wait_cnt_n = '0;
                    state_n    = RSP_HOLD;
                end else if (!spawn_pend_n) begin
                    wait_cnt_n = '0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wctl_q       <= '0;
            wctl_valid_q <= 1'b0;
            wctl_wid_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_wid_q    <= '0;
            pend_q       <= '0;
            pend_wid_q   <= '0;
            snap_q       <= '0;
            spawn_pend_q <= 1'b0;
            wait_cnt_q   <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            wctl_q       <= wctl_n;
            wctl_valid_q <= wctl_valid_n;
            wctl_wid_q   <= wctl_wid_n;
            rsp_valid_q  <= rsp_valid_n;
            rsp_wid_q    <= rsp_wid_n;
            pend_q       <= pend_n;
            pend_wid_q   <= pend_wid_n;
            snap_q       <= snap_n;
            spawn_pend_q <= spawn_pend_n;
            wait_cnt_q   <= wait_cnt_n;
            stall_q      <= stall_n;
        end
    end

    // req_ready is forced low during reset so every output reads zero.
    assign bus.req_ready         = req_ready_c && !reset;
    assign bus.wctl_valid        = wctl_valid_q;
    assign bus.wctl_wid          = wctl_wid_q;
    assign bus.wctl_tmc_valid    = wctl_q.tmc.valid;
    assign bus.wctl_tmc_mask     = wctl_q.tmc.mask;
    assign bus.wctl_wspawn_valid = wctl_q.wspawn.valid;
    assign bus.wctl_wspawn_wmask = wctl_q.wspawn.wmask;
    assign bus.wctl_wspawn_pc    = wctl_q.wspawn.pc;
    assign bus.wctl_bar_valid    = wctl_q.bar.valid;
    assign bus.wctl_bar_id       = wctl_q.bar.id;
    assign bus.wctl_bar_global   = wctl_q.bar.is_global;
    assign bus.wctl_bar_size_m1  = wctl_q.bar.size_m1;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_wid           = rsp_wid_q;
    assign bus.stall_err         = stall_q;

endmodule

// File: tb/tb_vx_wctl_issue.sv
// Directed bench for vx_wctl_issue (WAIT_LIMIT=8).
// Each task drives one scenario and compares the sampled outputs
// against hand-computed values.
module tb_vx_wctl_issue;
    import vx_wctl_issue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vx_wctl_issue_if bus ();

    vx_wctl_issue #(.WAIT_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic                   wctl_valid;
        logic [NW_WIDTH-1:0]    wctl_wid;
        logic                   tmc_valid;
        logic [NUM_THREADS-1:0] tmc_mask;
        logic                   wspawn_valid;
        logic [NUM_WARPS-1:0]   wspawn_wmask;
        logic [PC_BITS-1:0]     wspawn_pc;
        logic                   bar_valid;
        logic [NB_WIDTH-1:0]    bar_id;
        logic                   bar_global;
        logic [NW_WIDTH-1:0]    bar_size_m1;
        logic                   rsp_valid;
        logic [NW_WIDTH-1:0]    rsp_wid;
        logic                   stall_err;
    } obs_t;

    // Snapshot of all registered outputs; rsp_wid only matters while valid.
    function automatic obs_t obs();
        obs_t o;
        o.wctl_valid   = bus.wctl_valid;
        o.wctl_wid     = bus.wctl_wid;
        o.tmc_valid    = bus.wctl_tmc_valid;
        o.tmc_mask     = bus.wctl_tmc_mask;
        o.wspawn_valid = bus.wctl_wspawn_valid;
        o.wspawn_wmask = bus.wctl_wspawn_wmask;
        o.wspawn_pc    = bus.wctl_wspawn_pc;
        o.bar_valid    = bus.wctl_bar_valid;
        o.bar_id       = bus.wctl_bar_id;
        o.bar_global   = bus.wctl_bar_global;
        o.bar_size_m1  = bus.wctl_bar_size_m1;
        o.rsp_valid    = bus.rsp_valid;
        o.rsp_wid      = bus.rsp_valid ? bus.rsp_wid : '0;
        o.stall_err    = bus.stall_err;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [NW_WIDTH-1:0] wid,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_wid   = wid;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
    endtask

    task automatic test_reset();
        obs_t e;
        reset = 1'b1;
        drive(1'b0, 2'd0, '0, '0, '0);
        bus.active_warps   = 4'b0001;
        bus.is_single_warp = 1'b1;
        bus.rsp_ready      = 1'b1;
        repeat (2) step();
        e = '0;
        total++; if (obs() !== e) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), e); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        reset = 1'b0;
        step();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b want=1", bus.req_ready); end
        total++; if (obs() !== e) begin bad++; $display("FAIL idle_outputs got=%h want=%h", obs(), e); end
    endtask

    task automatic test_tmc();
        obs_t e;
        drive(1'b1, 2'd0, 2'd2, 32'h0000_000B, 32'h0);
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL tmc_ready got=%b want=1", bus.req_ready); end
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd2; e.tmc_valid = 1'b1; e.tmc_mask = 4'hB;
        e.rsp_valid = 1'b1; e.rsp_wid = 2'd2;
        total++; if (obs() !== e) begin bad++; $display("FAIL tmc_pulse got=%h want=%h", obs(), e); end
        step();
        e = '0;
        total++; if (obs() !== e) begin bad++; $display("FAIL tmc_one_cycle got=%h want=%h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]          op  [6];
        logic [NW_WIDTH-1:0] wid [6];
        logic [31:0]         rs1 [6];
        logic [31:0]         rs2 [6];
        obs_t                e   [6];
        for (int i = 0; i < 6; i++) e[i] = '0;
        // TMC with zero mask: warp terminates, still pulsed.
        op[0] = 2'd0; wid[0] = 2'd1; rs1[0] = 32'h0000_0010; rs2[0] = 32'h0;
        e[0].wctl_valid = 1'b1; e[0].wctl_wid = 2'd1; e[0].tmc_valid = 1'b1; e[0].tmc_mask = 4'h0;
        // BAR global id 2, size 0 clamps to 4 warps.
        op[1] = 2'd2; wid[1] = 2'd3; rs1[1] = 32'h8000_0002; rs2[1] = 32'h0;
        e[1].wctl_valid = 1'b1; e[1].wctl_wid = 2'd3; e[1].bar_valid = 1'b1; e[1].bar_id = 2'd2;
        e[1].bar_global = 1'b1; e[1].bar_size_m1 = 2'd3;
        // BAR size 1.
        op[2] = 2'd2; wid[2] = 2'd0; rs1[2] = 32'h0000_0001; rs2[2] = 32'h1;
        e[2].wctl_valid = 1'b1; e[2].wctl_wid = 2'd0; e[2].bar_valid = 1'b1; e[2].bar_id = 2'd1;
        // BAR size 9 clamps to 4.
        op[3] = 2'd2; wid[3] = 2'd1; rs1[3] = 32'h0000_0003; rs2[3] = 32'h9;
        e[3].wctl_valid = 1'b1; e[3].wctl_wid = 2'd1; e[3].bar_valid = 1'b1; e[3].bar_id = 2'd3;
        e[3].bar_size_m1 = 2'd3;
        // TMC uses only the low thread bits.
        op[4] = 2'd0; wid[4] = 2'd3; rs1[4] = 32'hFFFF_FFF7; rs2[4] = 32'h0;
        e[4].wctl_valid = 1'b1; e[4].wctl_wid = 2'd3; e[4].tmc_valid = 1'b1; e[4].tmc_mask = 4'h7;
        // Reserved op: response only.
        op[5] = 2'd3; wid[5] = 2'd2; rs1[5] = 32'hFFFF_FFFF; rs2[5] = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            e[i].rsp_valid = 1'b1;
            e[i].rsp_wid   = wid[i];
        end
        drive(1'b1, op[0], wid[0], rs1[0], rs2[0]);
        step();
        for (int i = 1; i < 6; i++) begin
            total++; if (obs() !== e[i-1]) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i - 1, obs(), e[i-1]); end
            drive(1'b1, op[i], wid[i], rs1[i], rs2[i]);
            #1;
            total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b want=1", i, bus.req_ready); end
            step();
        end
        drive(1'b0, 2'd0, '0, '0, '0);
        total++; if (obs() !== e[5]) begin bad++; $display("FAIL b2b_5 got=%h want=%h", obs(), e[5]); end
        step();
        total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL b2b_idle got=%h want=0", obs()); end
    endtask

    task automatic test_wspawn_single();
        obs_t e;
        bus.active_warps   = 4'b0001;
        bus.is_single_warp = 1'b1;
        drive(1'b1, 2'd1, 2'd0, 32'd3, 32'h0000_0400);
        step();
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd0; e.wspawn_valid = 1'b1;
        e.wspawn_wmask = 4'b0110; e.wspawn_pc = 30'h100; e.rsp_valid = 1'b1; e.rsp_wid = 2'd0;
        total++; if (obs() !== e) begin bad++; $display("FAIL spawn_pulse got=%h want=%h", obs(), e); end
        drive(1'b1, 2'd0, 2'd1, 32'h0000_000F, 32'h0);
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL spawn_block_0 got=%b want=0", bus.req_ready); end
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL spawn_block_%0d got=%b want=0", i, bus.req_ready); end
            total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL spawn_quiet_%0d got=%h want=0", i, obs()); end
        end
        bus.active_warps   = 4'b0111;
        bus.is_single_warp = 1'b0;
        step();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL spawn_release got=%b want=1", bus.req_ready); end
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd1; e.tmc_valid = 1'b1; e.tmc_mask = 4'hF;
        e.rsp_valid = 1'b1; e.rsp_wid = 2'd1;
        total++; if (obs() !== e) begin bad++; $display("FAIL spawn_next_tmc got=%h want=%h", obs(), e); end
        step();
    endtask

    task automatic test_wspawn_wait();
        obs_t e;
        bus.active_warps   = 4'b0001;
        bus.is_single_warp = 1'b0;
        drive(1'b1, 2'd1, 2'd1, 32'd0, 32'h0000_0008);
        step();
        // Second spawn queued behind the first.
        drive(1'b1, 2'd1, 2'd2, 32'd2, 32'h0000_0020);
        for (int i = 1; i <= 5; i++) begin
            step();
            total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL wait_quiet_%0d got=%h want=0", i, obs()); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL wait_block_%0d got=%b want=0", i, bus.req_ready); end
        end
        bus.is_single_warp = 1'b1;
        step();
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd1; e.wspawn_valid = 1'b1;
        e.wspawn_wmask = 4'b1110; e.wspawn_pc = 30'h2; e.rsp_valid = 1'b1; e.rsp_wid = 2'd1;
        total++; if (obs() !== e) begin bad++; $display("FAIL wait_pulse got=%h want=%h", obs(), e); end
        bus.is_single_warp = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL wait_pend_%0d got=%b want=0", i, bus.req_ready); end
            total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL wait_pend_quiet_%0d got=%h want=0", i, obs()); end
        end
        bus.active_warps = 4'b1111;
        step();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL wait_release got=%b want=1", bus.req_ready); end
        step();
        total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL wait_second_held got=%h want=0", obs()); end
        drive(1'b0, 2'd0, '0, '0, '0);
        bus.is_single_warp = 1'b1;
        step();
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd2; e.wspawn_valid = 1'b1;
        e.wspawn_wmask = 4'b0010; e.wspawn_pc = 30'h8; e.rsp_valid = 1'b1; e.rsp_wid = 2'd2;
        total++; if (obs() !== e) begin bad++; $display("FAIL wait_second_pulse got=%h want=%h", obs(), e); end
        bus.active_warps = 4'b0011;
        step();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL wait_second_release got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_rsp_hold();
        obs_t e;
        bus.rsp_ready = 1'b1;
        drive(1'b1, 2'd0, 2'd3, 32'h0000_0005, 32'h0);
        step();
        bus.rsp_ready = 1'b0;
        drive(1'b1, 2'd2, 2'd1, 32'h0000_0002, 32'h0000_0002);
        #1;
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd3; e.tmc_valid = 1'b1; e.tmc_mask = 4'h5;
        e.rsp_valid = 1'b1; e.rsp_wid = 2'd3;
        total++; if (obs() !== e) begin bad++; $display("FAIL hold_pulse got=%h want=%h", obs(), e); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_0 got=%b want=0", bus.req_ready); end
        e = '0; e.rsp_valid = 1'b1; e.rsp_wid = 2'd3;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (obs() !== e) begin bad++; $display("FAIL hold_rsp_%0d got=%h want=%h", i, obs(), e); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d got=%b want=0", i, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=%b want=1", bus.req_ready); end
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        e = '0; e.wctl_valid = 1'b1; e.wctl_wid = 2'd1; e.bar_valid = 1'b1; e.bar_id = 2'd2;
        e.bar_size_m1 = 2'd1; e.rsp_valid = 1'b1; e.rsp_wid = 2'd1;
        total++; if (obs() !== e) begin bad++; $display("FAIL hold_next_bar got=%h want=%h", obs(), e); end
        step();
        total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL hold_idle got=%h want=0", obs()); end
    endtask

    task automatic test_stall();
        obs_t e;
        bus.active_warps   = 4'b0001;
        bus.is_single_warp = 1'b0;
        drive(1'b1, 2'd1, 2'd0, 32'd2, 32'h0);
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        repeat (7) step();
        total++; if (bus.stall_err !== 1'b0) begin bad++; $display("FAIL stall_early got=%b want=0", bus.stall_err); end
        step();
        e = '0; e.stall_err = 1'b1;
        total++; if (obs() !== e) begin bad++; $display("FAIL stall_set got=%h want=%h", obs(), e); end
        step();
        total++; if (obs() !== e) begin bad++; $display("FAIL stall_sticky got=%h want=%h", obs(), e); end
        reset = 1'b1;
        #1;
        total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL stall_reset got=%h want=0", obs()); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL stall_reset_ready got=%b want=0", bus.req_ready); end
        step();
        reset = 1'b0;
        step();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL stall_after_reset got=%b want=1", bus.req_ready); end
        bus.is_single_warp = 1'b1;
        step();
        total++; if (obs() !== obs_t'('0)) begin bad++; $display("FAIL stall_dropped got=%h want=0", obs()); end
    endtask

    initial begin
        test_reset();
        test_tmc();
        test_back_to_back();
        test_wspawn_single();
        test_wspawn_wait();
        test_rsp_hold();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
